// File: rtl/jtag_dap_seq.sv
// jtag_dap_seq: sequences jtagIF IR/TFR/RESET scans into complete ADIv5 JTAG-DP transactions,
// caching IR, retrying on WAIT and collecting posted read data through DP RDBUFF.
module jtag_dap_seq #(
    parameter int unsigned WAIT_RETRIES = 16,
    parameter logic [3:0]  IR_DPACC     = 4'hA,
    parameter logic [3:0]  IR_APACC     = 4'hB
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_apndp_i,
    input  logic        req_rnw_i,
    input  logic [1:0]  req_addr32_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [2:0]  rsp_ack_o,
    output logic [31:0] rsp_rdata_o,
    input  logic        line_rst_i,
    output logic [1:0]  jt_cmd_o,
    output logic [3:0]  jt_ir_o,
    output logic [1:0]  jt_addr32_o,
    output logic        jt_rnw_o,
    output logic        jt_apndp_o,
    output logic [31:0] jt_dwrite_o,
    output logic        jt_go_o,
    input  logic        jt_idle_i,
    input  logic [2:0]  jt_ack_i,
    input  logic [31:0] jt_dread_i
);
    typedef enum logic [2:0] {S_IDLE, S_SETIR, S_XFER, S_RDBUF, S_RESP, S_LRST} state_t;
    localparam logic [7:0] WR = 8'(WAIT_RETRIES);
    localparam logic [2:0] ACK_OK = 3'b010, ACK_WAIT = 3'b001;
    state_t      state_q, state_d;
    logic        ph_q, ph_d, rdb_q, rdb_d, ir_vld_q, ir_vld_d, rst_pend_q, rst_pend_d;
    logic [3:0]  ir_q, ir_d;
    logic [7:0]  retry_q, retry_d;
    logic        apndp_q, apndp_d, rnw_q, rnw_d;
    logic [1:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [2:0]  ack_q, ack_d;
    logic        op, done, accept;
    logic [3:0]  ir_tgt, ir_req;

    // ph_q: 0 = ISSUE (go high until jtagIF goes busy), 1 = DONE (wait for idle to return)
    assign op     = state_q inside {S_SETIR, S_XFER, S_RDBUF, S_LRST};
    assign done   = op & ph_q & jt_idle_i;
    assign accept = req_valid_i & req_ready_o;
    assign ir_req = req_apndp_i ? IR_APACC : IR_DPACC;
    assign ir_tgt = (apndp_q & ~rdb_q) ? IR_APACC : IR_DPACC;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            ph_q       <= 1'b0;
            rdb_q      <= 1'b0;
            ir_vld_q   <= 1'b0;
            rst_pend_q <= 1'b0;
            ir_q       <= IR_DPACC;
            retry_q    <= 8'd0;
            apndp_q    <= 1'b0;
            rnw_q      <= 1'b0;
            addr_q     <= 2'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            ack_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            rdb_q      <= rdb_d;
            ir_vld_q   <= ir_vld_d;
            rst_pend_q <= rst_pend_d;
            ir_q       <= ir_d;
            retry_q    <= retry_d;
            apndp_q    <= apndp_d;
            rnw_q      <= rnw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ph_d       = (op & ~ph_q & ~jt_idle_i) ? 1'b1 : ph_q;
        rdb_d      = rdb_q;
        ir_vld_d   = ir_vld_q;
        rst_pend_d = rst_pend_q | line_rst_i;
        ir_d       = ir_q;
        retry_d    = retry_q;
        apndp_d    = apndp_q;
        rnw_d      = rnw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ack_d      = ack_q;
        unique case (state_q)
            S_IDLE: begin
                ph_d = 1'b0;
                if (rst_pend_q) state_d = S_LRST;
                else if (accept) begin
                    apndp_d = req_apndp_i;
                    rnw_d   = req_rnw_i;
                    addr_d  = req_addr32_i;
                    wdata_d = req_wdata_i;
                    rdb_d   = 1'b0;
                    state_d = (ir_vld_q && ir_q == ir_req) ? S_XFER : S_SETIR;
                end
            end
            S_SETIR: if (done) begin
                ph_d     = 1'b0;
                ir_d     = ir_tgt;
                ir_vld_d = 1'b1;
                state_d  = rdb_q ? S_RDBUF : S_XFER;
            end
            S_XFER, S_RDBUF: if (done) begin
                ph_d = 1'b0;
                if (jt_ack_i == ACK_WAIT && retry_q < WR) retry_d = retry_q + 8'd1;
                else if (jt_ack_i == ACK_OK && state_q == S_XFER && rnw_q) begin
                    rdb_d   = 1'b1;
                    retry_d = 8'd0;
                    state_d = (ir_vld_q && ir_q == IR_DPACC) ? S_RDBUF : S_SETIR;
                end else begin
                    state_d = S_RESP;
                    ack_d   = jt_ack_i;
                    if (jt_ack_i == ACK_OK && state_q == S_RDBUF) rdata_d = jt_dread_i;
                end
            end
            S_RESP: if (rsp_ready_i) begin
                state_d = S_IDLE;
                retry_d = 8'd0;
            end
            S_LRST: if (done) begin
                ph_d       = 1'b0;
                ir_vld_d   = 1'b0;
                rst_pend_d = line_rst_i;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == S_IDLE) & jt_idle_i & ~rst_pend_q & ~line_rst_i;
        rsp_valid_o = state_q == S_RESP;
        rsp_ack_o   = ack_q;
        rsp_rdata_o = rdata_q;
        jt_go_o     = op & ~ph_q;
        jt_cmd_o    = (state_q == S_LRST) ? 2'd3 : (state_q inside {S_XFER, S_RDBUF}) ? 2'd1 : 2'd0;
        jt_ir_o     = (state_q == S_SETIR) ? ir_tgt : IR_DPACC;
        jt_addr32_o = (state_q == S_RDBUF) ? 2'b11 : (state_q == S_XFER) ? addr_q : 2'b00;
        jt_rnw_o    = (state_q == S_RDBUF) | ((state_q == S_XFER) & rnw_q);
        jt_apndp_o  = (state_q == S_XFER) & apndp_q;
        jt_dwrite_o = (state_q == S_XFER) ? wdata_q : 32'd0;
    end
endmodule

// File: tb/tb_jtag_dap_seq.sv
// tb_jtag_dap_seq: directed tests of jtag_dap_seq against a small behavioural jtagIF model.
module tb_jtag_dap_seq;
    logic        clk = 0, rst_n = 0;
    logic        req_valid = 0, req_apndp = 0, req_rnw = 0, rsp_ready = 0, line_rst = 0;
    logic [1:0]  req_addr32 = 0;
    logic [31:0] req_wdata = 0;
    logic        req_ready, rsp_valid, jt_rnw, jt_apndp, jt_go;
    logic [2:0]  rsp_ack;
    logic [31:0] rsp_rdata, jt_dwrite;
    logic [1:0]  jt_cmd, jt_addr32;
    logic [3:0]  jt_ir;
    logic        jt_idle = 1;
    logic [2:0]  jt_ack = 0;
    logic [31:0] jt_dread = 0;
    int checks = 0, errors = 0;

    typedef struct {logic [1:0] cmd; logic [3:0] ir; logic [1:0] addr; logic apndp; logic rnw; logic [31:0] wd;} op_t;
    op_t op_log[$];
    logic [2:0] ack_script[$];
    logic [31:0] rdbuf_val = 0;
    op_t cur;
    int busy = 0;

    jtag_dap_seq #(.WAIT_RETRIES(2), .IR_DPACC(4'hA), .IR_APACC(4'hB)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_apndp_i(req_apndp),
        .req_rnw_i(req_rnw), .req_addr32_i(req_addr32), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_ack_o(rsp_ack), .rsp_rdata_o(rsp_rdata),
        .line_rst_i(line_rst), .jt_cmd_o(jt_cmd), .jt_ir_o(jt_ir), .jt_addr32_o(jt_addr32),
        .jt_rnw_o(jt_rnw), .jt_apndp_o(jt_apndp), .jt_dwrite_o(jt_dwrite), .jt_go_o(jt_go),
        .jt_idle_i(jt_idle), .jt_ack_i(jt_ack), .jt_dread_i(jt_dread)
    );

    always #5 clk = ~clk;

    // jtagIF model: each op is busy for 4 cycles, TFR acks come from ack_script (default OK)
    always @(posedge clk) begin
        if (jt_idle && jt_go) begin
            cur = '{jt_cmd, jt_ir, jt_addr32, jt_apndp, jt_rnw, jt_dwrite};
            op_log.push_back(cur);
            jt_idle <= 0;
            busy <= 3;
        end else if (!jt_idle) begin
            if (busy == 0) begin
                jt_idle <= 1;
                jt_ack <= (cur.cmd == 2'd1 && ack_script.size() > 0) ? ack_script.pop_front() : 3'b010;
                jt_dread <= (cur.cmd == 2'd1 && cur.addr == 2'b11 && !cur.apndp && cur.rnw) ? rdbuf_val : 32'h0;
            end else busy <= busy - 1;
        end
    end

    task automatic run(input logic ap, input logic rnw, input logic [1:0] a, input logic [31:0] wd,
                       output logic [2:0] ack, output logic [31:0] rd);
        int n = 0;
        req_apndp = ap; req_rnw = rnw; req_addr32 = a; req_wdata = wd; req_valid = 1;
        while (!req_ready && n < 300) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 0;
        n = 0;
        while (!rsp_valid && n < 500) begin @(posedge clk); #1; n++; end
        checks++;
        if (!rsp_valid) begin errors++; $display("FAIL rsp_timeout: rsp_valid=%0b required 1", rsp_valid); end
        ack = rsp_ack; rd = rsp_rdata;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    function automatic int count_tfr(input bit rdbuf_only);
        int c = 0;
        foreach (op_log[i]) if (op_log[i].cmd == 2'd1 && (!rdbuf_only || (op_log[i].addr == 2'b11 && !op_log[i].apndp))) c++;
        return c;
    endfunction

    logic [2:0] ack;
    logic [31:0] rd;

    task automatic test_reset;
        checks++; if (jt_go !== 0) begin errors++; $display("FAIL reset_go: got %0b required 0", jt_go); end
        checks++; if (rsp_valid !== 0) begin errors++; $display("FAIL reset_rsp_valid: got %0b required 0", rsp_valid); end
        checks++; if (rsp_ack !== 0 || rsp_rdata !== 0) begin errors++; $display("FAIL reset_rsp: got %h/%h required 0/0", rsp_ack, rsp_rdata); end
        checks++; if (jt_cmd !== 0 || jt_ir !== 4'hA || jt_dwrite !== 0) begin errors++; $display("FAIL reset_jt: cmd %0d ir %h dw %h required 0 a 0", jt_cmd, jt_ir, jt_dwrite); end
        checks++; if (req_ready !== 1) begin errors++; $display("FAIL reset_ready: got %0b required 1", req_ready); end
    endtask

    task automatic test_dp_write;
        op_log.delete();
        run(0, 0, 2'd1, 32'h12345678, ack, rd);
        checks++; if (op_log.size() !== 2) begin errors++; $display("FAIL dpw_nops: got %0d required 2", op_log.size()); end
        else begin
            checks++; if (op_log[0].cmd !== 0 || op_log[0].ir !== 4'hA) begin errors++; $display("FAIL dpw_setir: cmd %0d ir %h required 0 a", op_log[0].cmd, op_log[0].ir); end
            checks++; if (op_log[1].cmd !== 1 || op_log[1].addr !== 1 || op_log[1].apndp !== 0 || op_log[1].rnw !== 0 || op_log[1].wd !== 32'h12345678)
                begin errors++; $display("FAIL dpw_tfr: cmd %0d a %0d ap %0b rnw %0b wd %h required 1 1 0 0 12345678", op_log[1].cmd, op_log[1].addr, op_log[1].apndp, op_log[1].rnw, op_log[1].wd); end
        end
        checks++; if (ack !== 3'b010) begin errors++; $display("FAIL dpw_ack: got %b required 010", ack); end
    endtask

    task automatic test_ap_write;
        op_log.delete();
        run(1, 0, 2'd0, 32'hA5A5_0001, ack, rd);
        checks++; if (op_log.size() !== 2 || op_log[0].cmd !== 0 || op_log[0].ir !== 4'hB) begin errors++; $display("FAIL apw_setir: nops %0d required 2 with IR b", op_log.size()); end
        checks++; if (ack !== 3'b010) begin errors++; $display("FAIL apw_ack: got %b required 010", ack); end
        op_log.delete();
        run(1, 0, 2'd0, 32'hA5A5_0002, ack, rd);
        checks++; if (op_log.size() !== 1 || op_log[0].cmd !== 1 || op_log[0].apndp !== 1 || op_log[0].wd !== 32'hA5A5_0002)
            begin errors++; $display("FAIL apw_cached: nops %0d required 1 TFR", op_log.size()); end
    endtask

    task automatic test_ap_read;
        op_log.delete();
        rdbuf_val = 32'hDEADBEEF;
        run(1, 1, 2'd2, 32'hFFFF_FFFF, ack, rd);
        checks++; if (op_log.size() !== 3) begin errors++; $display("FAIL apr_nops: got %0d required 3", op_log.size()); end
        else begin
            checks++; if (op_log[0].cmd !== 1 || op_log[0].apndp !== 1 || op_log[0].rnw !== 1 || op_log[0].addr !== 2)
                begin errors++; $display("FAIL apr_tfr: cmd %0d ap %0b rnw %0b a %0d required 1 1 1 2", op_log[0].cmd, op_log[0].apndp, op_log[0].rnw, op_log[0].addr); end
            checks++; if (op_log[1].cmd !== 0 || op_log[1].ir !== 4'hA) begin errors++; $display("FAIL apr_setir: cmd %0d ir %h required 0 a", op_log[1].cmd, op_log[1].ir); end
            checks++; if (op_log[2].cmd !== 1 || op_log[2].apndp !== 0 || op_log[2].rnw !== 1 || op_log[2].addr !== 3)
                begin errors++; $display("FAIL apr_rdbuf: cmd %0d ap %0b rnw %0b a %0d required 1 0 1 3", op_log[2].cmd, op_log[2].apndp, op_log[2].rnw, op_log[2].addr); end
        end
        checks++; if (ack !== 3'b010 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL apr_rsp: got %b/%h required 010/deadbeef", ack, rd); end
    endtask

    task automatic test_wait;
        op_log.delete();
        ack_script = '{3'b001, 3'b001, 3'b010};
        run(1, 0, 2'd1, 32'h0000_0055, ack, rd);
        checks++; if (count_tfr(0) !== 3 || ack !== 3'b010) begin errors++; $display("FAIL wait_ok: tfrs %0d ack %b required 3 010", count_tfr(0), ack); end
        op_log.delete();
        ack_script = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        run(1, 0, 2'd1, 32'h0000_0066, ack, rd);
        checks++; if (count_tfr(0) !== 3 || ack !== 3'b001) begin errors++; $display("FAIL wait_limit: tfrs %0d ack %b required 3 001", count_tfr(0), ack); end
        ack_script.delete();
    endtask

    task automatic test_fault;
        op_log.delete();
        ack_script = '{3'b100};
        rdbuf_val = 32'h1111_2222;
        run(1, 1, 2'd0, 32'h0, ack, rd);
        checks++; if (count_tfr(0) !== 1 || count_tfr(1) !== 0) begin errors++; $display("FAIL fault_ops: tfrs %0d rdbuf %0d required 1 0", count_tfr(0), count_tfr(1)); end
        checks++; if (ack !== 3'b100 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL fault_rsp: got %b/%h required 100/deadbeef", ack, rd); end
        ack_script.delete();
    endtask

    task automatic test_line_rst;
        int n = 0;
        op_log.delete();
        rdbuf_val = 32'hCAFEF00D;
        fork
            run(1, 1, 2'd3, 32'h0, ack, rd);
            begin
                while (!jt_go && n < 100) begin @(posedge clk); #1; n++; end
                @(posedge clk); #1; line_rst = 1;
                @(posedge clk); #1; line_rst = 0;
            end
        join
        checks++; if (ack !== 3'b010 || rd !== 32'hCAFEF00D) begin errors++; $display("FAIL lrst_read: got %b/%h required 010/cafef00d", ack, rd); end
        n = 0;
        while (!(op_log.size() >= 4 && jt_idle) && n < 100) begin @(posedge clk); #1; n++; end
        checks++; if (op_log.size() !== 4 || op_log[op_log.size()-1].cmd !== 2'd3)
            begin errors++; $display("FAIL lrst_reset_op: nops %0d required 4 ending in RESET", op_log.size()); end
        op_log.delete();
        run(0, 0, 2'd2, 32'h7, ack, rd);
        checks++; if (op_log.size() !== 2 || op_log[0].cmd !== 0 || op_log[0].ir !== 4'hA)
            begin errors++; $display("FAIL lrst_setir: nops %0d required 2 starting SETIR a", op_log.size()); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        test_reset;
        test_dp_write;
        test_ap_write;
        test_ap_read;
        test_wait;
        test_fault;
        test_line_rst;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
